// File: rtl/perf_cnt_pkg.sv
// perf_cnt_pkg -- shared definitions for the performance counter bank.
//   snap_state_t : snapshot FSM states (IDLE, CAPTURE, DONE)
//   DEF_NUM_CH   : default number of counter channels
//   DEF_CNT_W    : default counter width
//   WRAP / SAT   : counter overflow modes (wrap to 0 / hold at max)
package perf_cnt_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DONE    = 2'd2
  } snap_state_t;

  localparam int DEF_NUM_CH = 3;
  localparam int DEF_CNT_W  = 20;

  localparam int WRAP = 0;
  localparam int SAT  = 1;

endpackage

// File: rtl/perf_cnt_channel.sv
// perf_cnt_channel -- one event counter with a sticky overflow flag.
// Ports:
//   clk    : clock, rising edge
//   rst    : asynchronous active-high reset
//   inc    : count one event this cycle
//   clr    : synchronous clear of counter and ovf (wins over inc)
//   freeze : ignore inc while high (ovf and clr unaffected)
//   cnt    : live counter value
//   ovf    : sticky overflow flag, cleared only by clr or rst
module perf_cnt_channel
  import perf_cnt_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter int SATURATE = WRAP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             freeze,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (clr) begin
      cnt <= '0;
      ovf <= 1'b0;
    end else if (inc && !freeze) begin
      if (cnt == '1) begin
        ovf <= 1'b1;
        // saturating channels simply keep the all-ones value
        if (SATURATE == WRAP) cnt <= '0;
      end else begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/perf_counter_bank.sv
// perf_counter_bank -- bank of NUM_CH event counters with snapshot shadows.
// Ports:
//   clk, rst  : clock (rising edge) and asynchronous active-high reset
//   inc, clr  : per-channel increment request / synchronous clear
//   freeze    : global hold of all increments
//   snap_req  : copy all live counters into the shadow registers
//   snap_done : one-cycle pulse while the snapshot FSM is in DONE
//   rd_sel    : shadow channel select; rd_data follows one cycle later
//   rd_data   : registered shadow value (0 for rd_sel >= NUM_CH)
//   ovf       : sticky per-channel overflow flags
//   irq       : threshold interrupt (only with PERF_CNT_IRQ_EN defined)
//   thresh    : shared interrupt threshold, 0 disables the compare
// Build option: define PERF_CNT_IRQ_EN to include the threshold interrupt;
// otherwise irq is tied low and thresh is unused.
module perf_counter_bank
  import perf_cnt_pkg::*;
#(
  parameter int  NUM_CH   = DEF_NUM_CH,
  parameter int  CNT_W    = DEF_CNT_W,
  parameter int  SATURATE = WRAP,
  localparam int RD_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_CH-1:0] inc,
  input  logic [NUM_CH-1:0] clr,
  input  logic              freeze,
  input  logic              snap_req,
  output logic              snap_done,
  input  logic [RD_W-1:0]   rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] ovf,
  output logic              irq,
  input  logic [CNT_W-1:0]  thresh
);

  logic [CNT_W-1:0] cnt    [NUM_CH];
  logic [CNT_W-1:0] shadow [NUM_CH];

  snap_state_t state_q, state_d;
  logic        capture;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    perf_cnt_channel #(
      .CNT_W   (CNT_W),
      .SATURATE(SATURATE)
    ) u_ch (
      .clk   (clk),
      .rst   (rst),
      .inc   (inc[g]),
      .clr   (clr[g]),
      .freeze(freeze),
      .cnt   (cnt[g]),
      .ovf   (ovf[g])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // The shadows load on the edge that enters CAPTURE, so they hold the
  // counter values seen before any increment or clear on that same edge.
  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (snap_req) begin
          state_d = CAPTURE;
          capture = 1'b1;
        end
      end
      CAPTURE: state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign snap_done = (state_q == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= '0;
    end else if (capture) begin
      for (int unsigned i = 0; i < NUM_CH; i++) shadow[i] <= cnt[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            rd_data <= '0;
    else if (32'(rd_sel) < 32'(NUM_CH)) rd_data <= shadow[rd_sel];
    else                                rd_data <= '0;
  end

`ifdef PERF_CNT_IRQ_EN
  // Per-channel pending bits keep irq up until every hitting channel is cleared.
  logic [NUM_CH-1:0] irq_pend;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      irq_pend <= '0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        if (clr[i])                                    irq_pend[i] <= 1'b0;
        else if (thresh != '0 && cnt[i] == thresh)     irq_pend[i] <= 1'b1;
      end
    end
  end

  assign irq = |irq_pend;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign irq           = 1'b0;
`endif

endmodule

// File: doc/perf_counter_bank.md
PERF_COUNTER_BANK -- requirements
Module: perf_counter_bank

Interface
REQ-001 Parameter NUM_CH, default 3, number of independent event counters (1..16).
REQ-002 Parameter CNT_W, default 20, counter width in bits (8..32).
REQ-003 Parameter SATURATE, default 0, 0 = wrap at max, 1 = hold at max.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 inc  input  NUM_CH  per-channel increment request, one count per cycle when high.
REQ-007 clr  input  NUM_CH  per-channel synchronous clear of counter and overflow flag.
REQ-008 freeze  input  1  global hold; all counters ignore inc while high.
REQ-009 snap_req  input  1  request snapshot of all counters into shadow registers.
REQ-010 snap_done  output  1  one-cycle pulse, shadow registers updated.
REQ-011 rd_sel  input  $clog2(NUM_CH)  shadow channel select.
REQ-012 rd_data  output  CNT_W  registered shadow value of channel rd_sel.
REQ-013 ovf  output  NUM_CH  sticky per-channel overflow flag.
REQ-014 irq  output  1  threshold interrupt (see Configuration).
REQ-015 thresh  input  CNT_W  threshold shared by all channels.

Function
REQ-016 Counter increments by 1 on an edge where inc[i]=1, freeze=0, clr[i]=0.
REQ-017 clr[i] has priority over inc[i]: same-cycle clr and inc yields counter 0, ovf[i]=0.
REQ-018 Wrap mode: increment at 2^CNT_W-1 yields 0 and sets ovf[i].
REQ-019 Saturate mode: increment at 2^CNT_W-1 holds max and sets ovf[i].
REQ-020 ovf[i] stays set until clr[i] or rst; freeze does not affect ovf.
REQ-021 Snapshot FSM states IDLE, CAPTURE, DONE; IDLE->CAPTURE on snap_req; CAPTURE->DONE unconditionally; DONE->IDLE unconditionally.
REQ-022 In CAPTURE, all shadow registers load the live counter values present at that edge, before any increment on that edge.
REQ-023 snap_done is high exactly in DONE (2 cycles after snap_req sampled).
REQ-024 snap_req while not IDLE is ignored; no queuing.
REQ-025 clr[i] during CAPTURE: shadow receives pre-clear value.
REQ-026 rd_data updates one cycle after rd_sel; rd_sel >= NUM_CH returns 0.
REQ-027 Shadow registers change only in CAPTURE and on rst.

Reset
REQ-028 On rst: all counters, shadows, ovf, rd_data = 0; snap_done = 0; irq = 0; FSM = IDLE.
REQ-029 rst mid-snapshot aborts it; no snap_done pulse follows.

Configuration
REQ-030 Macro PERF_CNT_IRQ_EN: when defined, irq registers high the cycle after any live counter equals thresh with thresh != 0, and stays high until every such channel is cleared or rst.
REQ-031 Without PERF_CNT_IRQ_EN: irq tied 0, thresh ignored, no compare logic synthesised; port list unchanged.

Structure
REQ-032 Package perf_cnt_pkg holds snapshot FSM state enum, default NUM_CH/CNT_W constants, mode constants WRAP/SAT.
REQ-033 Sub-module perf_cnt_channel implements one counter plus ovf flag, parametrised by CNT_W and SATURATE; instantiated NUM_CH times via generate.

Verification
REQ-034 inc[0]=1 for 5 cycles, freeze=0 -> counter0=5, snap_req, read rd_sel=0 -> rd_data=5.
REQ-035 CNT_W=8, SATURATE=0, 256 increments on ch1 -> counter1=0, ovf[1]=1; SATURATE=1 -> counter1=255, ovf[1]=1.
REQ-036 inc[2]=1 and clr[2]=1 same cycle at count 7 -> counter2=0, ovf[2]=0.
REQ-037 snap_req same cycle as inc[0] at count 9 -> shadow0=9, snap_done 2 cycles later; snap_req in CAPTURE ignored.
REQ-038 freeze=1 with inc all-ones for 10 cycles -> counters unchanged; rst during CAPTURE -> no snap_done, all outputs 0.
REQ-039 PERF_CNT_IRQ_EN defined, thresh=4, 4 increments on ch0 -> irq=1 next cycle; clr[0] -> irq=0.
